mem_io_fabric_endpoint: RTL and testbench

- Fabric-side endpoint of the HPS memory-I/O conduit. It receives command words on the control channel and data beats on the input channel, and buffers the input beats into a FIFO.
- Buffered beats feed a compute core over a valid/ready stream.
- Results from the core return to the HPS on the output channel, which obeys waitrequest.
- Sits between the memory-I/O system export and the numerical core.

---
 rtl/mem_io_pkg.sv | 13 +
 rtl/mem_io_fifo.sv | 42 ++++
 rtl/mem_io_fabric_endpoint.sv | 95 +++++++++
 tb/tb_mem_io_fabric_endpoint.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared opcodes, control-word field offsets, error bit indices and endpoint states
package mem_io_pkg;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_START = 4'd1;
  localparam logic [3:0] OP_ABORT = 4'd2;
  localparam logic [3:0] OP_CLEAR_ERR = 4'd3;
  localparam int ERR_OVF = 0;
  localparam int ERR_UNEXP = 1;
  localparam int ERR_ILL = 2;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/mem_io_fifo.sv
// mem_io_fifo: synchronous fifo with simultaneous push/pop, sync clear and async active-low reset
module mem_io_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mem_io_fabric_endpoint.sv
// mem_io_fabric_endpoint: hps memory-io conduit endpoint buffering input beats to a core and returning results
module mem_io_fabric_endpoint
  import mem_io_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [CTRL_W-1:0] ctrl_data_i,
  input  logic              ctrl_set_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_set_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_set_o,
  input  logic              out_waitrequest_i,
  output logic [DATA_W-1:0] core_in_data_o,
  output logic              core_in_valid_o,
  input  logic              core_in_ready_i,
  input  logic [DATA_W-1:0] core_out_data_i,
  input  logic              core_out_valid_i,
  output logic              core_out_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        err_o
);
  state_t state, state_nx;
  logic [3:0] op;
  logic [CNT_W-1:0] n, in_rem, out_rem, rem_eff;
  logic cmd_start, cmd_abort, cmd_clr, cmd_ill, idle_like, start_ok, in_run, in_ok;
  logic fifo_full, fifo_empty, fifo_clr, pop, push, xfer, accept;
  logic [2:0] err_set;
  assign op = ctrl_data_i[OP_MSB:OP_LSB];
  assign n = ctrl_data_i[CNT_W-1:0];
  assign cmd_start = ctrl_set_i && op == OP_START;
  assign cmd_abort = ctrl_set_i && op == OP_ABORT;
  assign cmd_clr = ctrl_set_i && op == OP_CLEAR_ERR;
  assign cmd_ill = ctrl_set_i && op > OP_CLEAR_ERR;
  assign idle_like = state == IDLE || state == DONE;
  assign start_ok = cmd_start && idle_like;
  assign in_run = start_ok ? n != '0 : state == RUN && !cmd_abort;
  assign rem_eff = start_ok ? n : in_rem;
  assign in_ok = in_set_i && in_run && rem_eff != '0;
  assign pop = core_in_valid_o && core_in_ready_i;
  assign push = in_ok && (!fifo_full || pop);
  assign fifo_clr = cmd_abort && state == RUN;
  assign xfer = out_set_o && !out_waitrequest_i;
  assign core_out_ready_o = state == RUN && (!out_set_o || !out_waitrequest_i);
  assign accept = core_out_valid_i && core_out_ready_o;
  assign core_in_valid_o = !fifo_empty;
  assign busy_o = state == RUN || state == FLUSH;
  assign done_o = state == DONE;
  mem_io_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_clk),
    .rst_n(reset_reset_n),
    .clr(fifo_clr),
    .push(push),
    .pop(pop),
    .din(in_data_i),
    .dout(core_in_data_o),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_comb begin
    err_set = '0;
    err_set[ERR_OVF] = in_ok && fifo_full && !pop;
    err_set[ERR_UNEXP] = in_set_i && !in_ok;
    err_set[ERR_ILL] = cmd_ill || (cmd_start && !idle_like);
    state_nx = state;
    if (idle_like)
      state_nx = start_ok ? (n == '0 ? DONE : RUN) : cmd_abort ? IDLE : state;
    else if (state == RUN)
      state_nx = cmd_abort ? FLUSH : (xfer && out_rem == CNT_W'(1)) ? DONE : RUN;
    else
      state_nx = out_set_o && out_waitrequest_i ? FLUSH : IDLE;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state <= IDLE;
      in_rem <= '0;
      out_rem <= '0;
      out_set_o <= 1'b0;
      out_data_o <= '0;
      err_o <= '0;
    end else begin
      state <= state_nx;
      in_rem <= fifo_clr ? '0 : rem_eff - CNT_W'(in_ok);
      out_rem <= start_ok ? n : out_rem - CNT_W'(xfer && out_rem != '0);
      out_set_o <= accept || (out_set_o && !xfer);
      if (accept) out_data_o <= core_out_data_i;
      err_o <= (cmd_clr ? 3'b000 : err_o) | err_set;
    end
endmodule

// File: tb/tb_mem_io_fabric_endpoint.sv
// tb_mem_io_fabric_endpoint: scoreboard bench with an echoing core model and directed command sequences
module tb_mem_io_fabric_endpoint;
  localparam int DATA_W = 128;
  localparam int CTRL_W = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W = 16;
  localparam logic [3:0] START = 4'd1, ABORT = 4'd2, CLR = 4'd3, BAD = 4'd7;
  logic clk_clk = 1'b0, reset_reset_n = 1'b0;
  logic [CTRL_W-1:0] ctrl_data_i = '0;
  logic ctrl_set_i = 1'b0, in_set_i = 1'b0, out_waitrequest_i = 1'b0, core_en = 1'b0;
  logic [DATA_W-1:0] in_data_i = '0;
  logic [DATA_W-1:0] out_data_o, core_in_data_o, core_out_data_i;
  logic out_set_o, core_in_valid_o, core_in_ready_i, core_out_valid_i, core_out_ready_o, busy_o, done_o;
  logic [2:0] err_o;
  logic [DATA_W-1:0] exp_q[$];
  int checks = 0, errors = 0;
  always #5 clk_clk = ~clk_clk;
  assign core_in_ready_i = core_en && core_out_ready_o;
  assign core_out_valid_i = core_in_valid_o && core_in_ready_i;
  assign core_out_data_i = core_in_data_o;
  mem_io_fabric_endpoint #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .ctrl_data_i(ctrl_data_i),
    .ctrl_set_i(ctrl_set_i),
    .in_data_i(in_data_i),
    .in_set_i(in_set_i),
    .out_data_o(out_data_o),
    .out_set_o(out_set_o),
    .out_waitrequest_i(out_waitrequest_i),
    .core_in_data_o(core_in_data_o),
    .core_in_valid_o(core_in_valid_o),
    .core_in_ready_i(core_in_ready_i),
    .core_out_data_i(core_out_data_i),
    .core_out_valid_i(core_out_valid_i),
    .core_out_ready_o(core_out_ready_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );
  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask
  task automatic ctrl(input logic [3:0] op, input logic [15:0] n);
    ctrl_data_i = {op, 12'h000, n};
    ctrl_set_i = 1'b1;
    tick();
    ctrl_set_i = 1'b0;
  endtask
  task automatic beat(input logic [DATA_W-1:0] d);
    in_data_i = d;
    in_set_i = 1'b1;
    tick();
    in_set_i = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int k = 0;
    while (!done_o && k < 50) begin
      tick();
      k++;
    end
    check(name, done_o, 1);
  endtask
  task automatic wait_out(input string name);
    int k = 0;
    while (!out_set_o && k < 20) begin
      tick();
      k++;
    end
    check(name, out_set_o, 1);
  endtask
  task automatic check_all_zero(input string name);
    check({name, "_out_set"}, out_set_o, 0);
    check({name, "_out_data"}, out_data_o, 0);
    check({name, "_busy"}, busy_o, 0);
    check({name, "_done"}, done_o, 0);
    check({name, "_err"}, err_o, 0);
    check({name, "_core_in_valid"}, core_in_valid_o, 0);
    check({name, "_core_in_data"}, core_in_data_o, 0);
    check({name, "_core_out_ready"}, core_out_ready_o, 0);
  endtask
  always @(negedge clk_clk)
    if (out_set_o && !out_waitrequest_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected no transfer", out_data_o);
      end else check("out_data", out_data_o, exp_q.pop_front());
    end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    check_all_zero("reset");
    tick();
    reset_reset_n = 1'b1;
    tick();
    core_en = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(DATA_W'(i));
    ctrl(START, 16'd4);
    for (int i = 1; i <= 4; i++) beat(DATA_W'(i));
    wait_done("t1_done");
    check("t1_err", err_o, 0);
    check("t1_busy", busy_o, 0);
    check("t1_q", exp_q.size(), 0);
    out_waitrequest_i = 1'b1;
    exp_q.push_back(DATA_W'('hA));
    exp_q.push_back(DATA_W'('hB));
    ctrl(START, 16'd2);
    check("t2_done_cleared", done_o, 0);
    beat(DATA_W'('hA));
    beat(DATA_W'('hB));
    wait_out("t2_out");
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_set", out_set_o, 1);
      check("t2_hold_data", out_data_o, DATA_W'('hA));
      check("t2_hold_ready", core_out_ready_o, 0);
      tick();
    end
    out_waitrequest_i = 1'b0;
    wait_done("t2_done");
    check("t2_err", err_o, 0);
    check("t2_q", exp_q.size(), 0);
    core_en = 1'b0;
    ctrl(START, 16'd10);
    for (int i = 1; i <= 10; i++) beat(DATA_W'(32'h100 + i));
    check("t3_ovf", err_o, 3'b001);
    check("t3_valid", core_in_valid_o, 1);
    check("t3_head", core_in_data_o, DATA_W'('h101));
    beat(DATA_W'('hDEAD));
    check("t3_rem_zero", err_o, 3'b011);
    ctrl(START, 16'd3);
    check("t3_start_in_run", err_o, 3'b111);
    ctrl(CLR, 16'd0);
    check("t3_clear", err_o, 0);
    ctrl(ABORT, 16'd0);
    check("t3_flush_busy", busy_o, 1);
    check("t3_fifo_cleared", core_in_valid_o, 0);
    tick();
    check("t3_idle", busy_o, 0);
    beat(DATA_W'('h9));
    check("t4_unexp", err_o, 3'b010);
    check("t4_fifo_empty", core_in_valid_o, 0);
    ctrl(CLR, 16'd0);
    ctrl(START, 16'd0);
    check("t4_done", done_o, 1);
    check("t4_busy", busy_o, 0);
    ctrl(BAD, 16'd0);
    check("t4_illegal", err_o, 3'b100);
    ctrl(CLR, 16'd0);
    check("t4_clear", err_o, 0);
    core_en = 1'b1;
    out_waitrequest_i = 1'b1;
    exp_q.push_back(DATA_W'('h55));
    ctrl(START, 16'd3);
    beat(DATA_W'('h55));
    wait_out("t5_out");
    ctrl(ABORT, 16'd0);
    for (int i = 0; i < 2; i++) begin
      check("t5_hold_set", out_set_o, 1);
      check("t5_hold_data", out_data_o, DATA_W'('h55));
      check("t5_flush_busy", busy_o, 1);
      check("t5_ready", core_out_ready_o, 0);
      tick();
    end
    out_waitrequest_i = 1'b0;
    tick();
    check("t5_idle", busy_o, 0);
    check("t5_done", done_o, 0);
    check("t5_out_set", out_set_o, 0);
    check("t5_fifo_empty", core_in_valid_o, 0);
    check("t5_q", exp_q.size(), 0);
    out_waitrequest_i = 1'b1;
    ctrl(START, 16'd2);
    beat(DATA_W'('h77));
    wait_out("t6_out");
    #2;
    reset_reset_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    tick();
    reset_reset_n = 1'b1;
    out_waitrequest_i = 1'b0;
    tick();
    check("t6_idle", busy_o, 0);
    check("t6_out_set", out_set_o, 0);
    check("final_q", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
